// File: rtl/arm_mul_pkg.sv
//------------------------------------------------------------------------------
// arm_mul_pkg : shared op encodings, state type and sizing for the multiplier
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package arm_mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

  localparam logic [1:0] MUL_OP_MUL   = 2'b00;
  localparam logic [1:0] MUL_OP_UMULL = 2'b01;
  localparam logic [1:0] MUL_OP_SMULL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

endpackage

`default_nettype wire

// File: rtl/arm_mul_if.sv
//------------------------------------------------------------------------------
// arm_mul_if : request/result bundle between the core and the multiply unit
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface arm_mul_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             acc_en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] acc_hi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             flag_n;
  logic             flag_z;

  modport master (
    output start, op, acc_en, a, b, acc_lo, acc_hi,
    input  busy, done, result_lo, result_hi, flag_n, flag_z
  );

  modport slave (
    input  start, op, acc_en, a, b, acc_lo, acc_hi,
    output busy, done, result_lo, result_hi, flag_n, flag_z
  );
endinterface

`default_nettype wire

// File: rtl/arm_mul_fsm.sv
//------------------------------------------------------------------------------
// arm_mul_fsm : state register, iteration counter and busy/done decode
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module arm_mul_fsm
  import arm_mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output mul_state_e state,
  output logic       busy,
  output logic       done
);

  mul_state_e       state_d, state_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             busy_q, done_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          count_d = '0;
        end
      end
      CALC: begin
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
          count_d = '0;
        end
      end
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with state_q
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign state = state_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

`default_nettype wire

// File: rtl/arm_mul_unit.sv
//------------------------------------------------------------------------------
// arm_mul_unit : radix-2 shift-add MUL/MLA/UMULL/SMULL(+acc) with 34-cycle latency
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module arm_mul_unit
  import arm_mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic     clk,
  input  logic     reset,
  arm_mul_if.slave bus
);

  localparam int PW = 2 * WIDTH;

  mul_state_e state;
  logic       fsm_busy, fsm_done;

  arm_mul_fsm #(
    .WIDTH (WIDTH),
    .CNT_W ($clog2(WIDTH))
  ) u_fsm (
    .clk   (clk),
    .reset (reset),
    .start (bus.start),
    .state (state),
    .busy  (fsm_busy),
    .done  (fsm_done)
  );

  logic [1:0]       op_d, op_q;
  logic             acc_en_d, acc_en_q;
  logic             neg_d, neg_q;
  logic [PW-1:0]    acc_d, acc_q;
  logic [PW-1:0]    mcand_d, mcand_q;
  logic [WIDTH-1:0] mplier_d, mplier_q;
  logic [PW-1:0]    prod_d, prod_q;
  logic [WIDTH-1:0] res_lo_d, res_lo_q, res_hi_d, res_hi_q;
  logic             flag_n_d, flag_n_q, flag_z_d, flag_z_q;

  logic             in_smull, long_q;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    p_signed, p_long;
  logic [WIDTH-1:0] p_short;

  // SMULL runs on magnitudes; 0x80000000 negates to itself, which is the right unsigned magnitude
  always_comb begin
    in_smull = (bus.op == MUL_OP_SMULL);
    mag_a    = (in_smull && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    mag_b    = (in_smull && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
  end

  always_comb begin
    long_q   = (op_q == MUL_OP_UMULL) || (op_q == MUL_OP_SMULL);
    p_signed = neg_q ? (~prod_q + 1'b1) : prod_q;
    p_long   = p_signed + (acc_en_q ? acc_q : '0);
    p_short  = p_signed[WIDTH-1:0] + (acc_en_q ? acc_q[WIDTH-1:0] : '0);
  end

  always_comb begin
    op_d     = op_q;
    acc_en_d = acc_en_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          acc_en_d = bus.acc_en;
          acc_d    = {bus.acc_hi, bus.acc_lo};
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = in_smull && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          prod_d   = '0;
        end
      end
      CALC: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
      FIX: begin
        if (long_q) begin
          res_lo_d = p_long[WIDTH-1:0];
          res_hi_d = p_long[PW-1:WIDTH];
          flag_n_d = p_long[PW-1];
          flag_z_d = (p_long == '0);
        end else begin
          res_lo_d = p_short;
          res_hi_d = '0;
          flag_n_d = p_short[WIDTH-1];
          flag_z_d = (p_short == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      acc_en_q <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      op_q     <= op_d;
      acc_en_q <= acc_en_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign bus.busy      = fsm_busy;
  assign bus.done      = fsm_done;
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_z    = flag_z_q;

endmodule

`default_nettype wire

// File: tb/tb_arm_mul_unit.sv
//------------------------------------------------------------------------------
// tb_arm_mul_unit : directed self-checking bench for arm_mul_unit
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_arm_mul_unit;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  arm_mul_if #(.WIDTH(32)) bus ();

  arm_mul_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start for one edge, then scrambles operands; returns in cycle 1
  task automatic issue(input logic [1:0] op, input logic ae, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ahi, input logic [31:0] alo);
    @(negedge clk);
    bus.op     = op;
    bus.acc_en = ae;
    bus.a      = a;
    bus.b      = b;
    bus.acc_hi = ahi;
    bus.acc_lo = alo;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op     = 2'b01;
    bus.acc_en = ~ae;
    bus.a      = 32'hDEADBEEF;
    bus.b      = 32'h0BADF00D;
    bus.acc_hi = 32'h12345678;
    bus.acc_lo = 32'h9ABCDEF0;
  endtask

  // Watches cycles 1..40; a missing pulse shows up as done_at = -1
  task automatic wait_done(output int done_at, output int pulses);
    done_at = -1;
    pulses  = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.done === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = c;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op = 2'b00; bus.acc_en = 1'b0; bus.a = '0; bus.b = '0; bus.acc_lo = '0; bus.acc_hi = '0;
    repeat (3) @(negedge clk);
    n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
    n_assert++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", bus.done); end
    n_assert++; if (bus.result_lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h expected 0", bus.result_lo); end
    n_assert++; if (bus.result_hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h expected 0", bus.result_hi); end
    n_assert++; if (bus.flag_n !== 1'b0) begin n_fail++; $display("FAIL reset_n got %b expected 0", bus.flag_n); end
    n_assert++; if (bus.flag_z !== 1'b0) begin n_fail++; $display("FAIL reset_z got %b expected 0", bus.flag_z); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic exp_busy, exp_done;
    issue(2'b00, 1'b0, 32'd7, 32'd6, 32'h0, 32'h0);
    for (int c = 1; c <= 40; c++) begin
      exp_busy = (c <= 34);
      exp_done = (c == 34);
      n_assert++;
      if (bus.busy !== exp_busy) begin n_fail++; $display("FAIL mul_busy cycle %0d got %b expected %b", c, bus.busy, exp_busy); end
      n_assert++;
      if (bus.done !== exp_done) begin n_fail++; $display("FAIL mul_done cycle %0d got %b expected %b", c, bus.done, exp_done); end
      @(negedge clk);
    end
    n_assert++; if (bus.result_lo !== 32'h0000002A) begin n_fail++; $display("FAIL mul_lo got %h expected 0000002a", bus.result_lo); end
    n_assert++; if (bus.result_hi !== 32'h0) begin n_fail++; $display("FAIL mul_hi got %h expected 0", bus.result_hi); end
    n_assert++; if (bus.flag_n !== 1'b0) begin n_fail++; $display("FAIL mul_n got %b expected 0", bus.flag_n); end
    n_assert++; if (bus.flag_z !== 1'b0) begin n_fail++; $display("FAIL mul_z got %b expected 0", bus.flag_z); end
  endtask

  task automatic test_umull();
    int d, p;
    issue(2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    wait_done(d, p);
    n_assert++; if (d != 34 || p != 1) begin n_fail++; $display("FAIL umull_done cycle %0d pulses %0d expected 34/1", d, p); end
    n_assert++; if (bus.result_hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL umull_hi got %h expected fffffffe", bus.result_hi); end
    n_assert++; if (bus.result_lo !== 32'h00000001) begin n_fail++; $display("FAIL umull_lo got %h expected 00000001", bus.result_lo); end
    n_assert++; if (bus.flag_n !== 1'b1) begin n_fail++; $display("FAIL umull_n got %b expected 1", bus.flag_n); end
    n_assert++; if (bus.flag_z !== 1'b0) begin n_fail++; $display("FAIL umull_z got %b expected 0", bus.flag_z); end
  endtask

  task automatic test_smull();
    int d, p;
    issue(2'b10, 1'b0, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0);
    wait_done(d, p);
    n_assert++; if (bus.result_hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL smull_neg_hi got %h expected ffffffff", bus.result_hi); end
    n_assert++; if (bus.result_lo !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL smull_neg_lo got %h expected fffffffa", bus.result_lo); end
    n_assert++; if (bus.flag_n !== 1'b1) begin n_fail++; $display("FAIL smull_neg_n got %b expected 1", bus.flag_n); end
    issue(2'b10, 1'b0, 32'h80000000, 32'h80000000, 32'h0, 32'h0);
    wait_done(d, p);
    n_assert++; if (bus.result_hi !== 32'h40000000) begin n_fail++; $display("FAIL smull_min_hi got %h expected 40000000", bus.result_hi); end
    n_assert++; if (bus.result_lo !== 32'h0) begin n_fail++; $display("FAIL smull_min_lo got %h expected 0", bus.result_lo); end
    n_assert++; if (bus.flag_n !== 1'b0) begin n_fail++; $display("FAIL smull_min_n got %b expected 0", bus.flag_n); end
  endtask

  task automatic test_accumulate();
    int d, p;
    issue(2'b01, 1'b1, 32'd2, 32'd3, 32'h0, 32'hFFFFFFFF);
    wait_done(d, p);
    n_assert++; if (bus.result_hi !== 32'h00000001) begin n_fail++; $display("FAIL umlal_hi got %h expected 00000001", bus.result_hi); end
    n_assert++; if (bus.result_lo !== 32'h00000005) begin n_fail++; $display("FAIL umlal_lo got %h expected 00000005", bus.result_lo); end
    issue(2'b00, 1'b1, 32'h00010000, 32'h00010000, 32'hFFFFFFFF, 32'h00000001);
    wait_done(d, p);
    n_assert++; if (bus.result_lo !== 32'h00000001) begin n_fail++; $display("FAIL mla_lo got %h expected 00000001", bus.result_lo); end
    n_assert++; if (bus.result_hi !== 32'h0) begin n_fail++; $display("FAIL mla_hi got %h expected 0", bus.result_hi); end
    n_assert++; if (bus.flag_z !== 1'b0) begin n_fail++; $display("FAIL mla_z got %b expected 0", bus.flag_z); end
  endtask

  task automatic test_reset_mid();
    int d, p, stray;
    issue(2'b01, 1'b0, 32'h0000FFFF, 32'h0000FFFF, 32'h0, 32'h0);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b expected 0", bus.busy); end
    n_assert++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %b expected 0", bus.done); end
    n_assert++; if (bus.result_lo !== 32'h0) begin n_fail++; $display("FAIL rstmid_lo got %h expected 0", bus.result_lo); end
    n_assert++; if (bus.result_hi !== 32'h0) begin n_fail++; $display("FAIL rstmid_hi got %h expected 0", bus.result_hi); end
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) stray++;
    end
    reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) stray++;
    end
    n_assert++; if (stray != 0) begin n_fail++; $display("FAIL rstmid_stray got %0d busy/done cycles expected 0", stray); end
    issue(2'b00, 1'b0, 32'd3, 32'd3, 32'h0, 32'h0);
    wait_done(d, p);
    n_assert++; if (d != 34 || p != 1) begin n_fail++; $display("FAIL rstmid_redo cycle %0d pulses %0d expected 34/1", d, p); end
    n_assert++; if (bus.result_lo !== 32'd9) begin n_fail++; $display("FAIL rstmid_lo9 got %h expected 00000009", bus.result_lo); end
    n_assert++; if (bus.result_hi !== 32'h0) begin n_fail++; $display("FAIL rstmid_hi0 got %h expected 0", bus.result_hi); end
  endtask

  task automatic test_ignore_start();
    int pulses, done_at;
    issue(2'b00, 1'b0, 32'h0, 32'h00001234, 32'h0, 32'h0);
    pulses  = 0;
    done_at = -1;
    for (int c = 1; c <= 80; c++) begin
      if (bus.done === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = c;
      end
      if (c == 10) begin
        bus.op = 2'b00; bus.acc_en = 1'b0; bus.a = 32'd5; bus.b = 32'd5; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    n_assert++; if (pulses != 1 || done_at != 34) begin n_fail++; $display("FAIL ignore_pulses got %0d at %0d expected 1 at 34", pulses, done_at); end
    n_assert++; if (bus.result_lo !== 32'h0) begin n_fail++; $display("FAIL ignore_lo got %h expected 0", bus.result_lo); end
    n_assert++; if (bus.flag_z !== 1'b1) begin n_fail++; $display("FAIL ignore_z got %b expected 1", bus.flag_z); end
    n_assert++; if (bus.flag_n !== 1'b0) begin n_fail++; $display("FAIL ignore_n got %b expected 0", bus.flag_n); end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    test_reset();
    test_mul();
    test_umull();
    test_smull();
    test_accumulate();
    test_reset_mid();
    test_ignore_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arm_mul_unit.md
Name: arm_mul_unit

Overview:
- Iterative multiply/multiply-accumulate unit directly downstream of the single-cycle ARM controller/datapath.
- Consumes the Mul request and register operands, and returns a 32- or 64-bit product for register write-back.
- AuxW selects the high word for the second destination register.
- Radix-2 shift-add design: fixed 34-cycle latency; the core stalls on busy.

Parameters:
WIDTH, 32, operand width in bits. Product and accumulator widths are 2*WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request pulse; sampled only in IDLE
op  input  2  00 MUL, 01 UMULL, 10 SMULL, 11 treated as MUL
acc_en  input  1  add accumulator (MLA/UMLAL/SMLAL)
a  input  WIDTH  multiplicand (Rm)
b  input  WIDTH  multiplier (Rs)
acc_lo  input  WIDTH  accumulator low word (Ra / RdLo)
acc_hi  input  WIDTH  accumulator high word (RdHi); ignored for MUL
busy  output  1  high whenever state != IDLE
done  output  1  single-cycle pulse; result valid
result_lo  output  WIDTH  product low word
result_hi  output  WIDTH  product high word; 0 for MUL
flag_n  output  1  sign of final result
flag_z  output  1  zero of final result

Behaviour:
- Reset (async, reset=0): state=IDLE. busy, done, result_lo, result_hi, flag_n, flag_z, internal regs and counter all 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1, latch op, acc_en, acc_hi:acc_lo.
  - Latch multiplicand/multiplier magnitudes: |a| and |b| when op=SMULL, raw values otherwise. |0x80000000| = 0x80000000 as unsigned.
  - Latch neg = a[31]^b[31] when op=SMULL, else 0. Clear the 64-bit product register and count. Go to CALC.
- CALC: exactly WIDTH cycles.
  - If multiplier LSB=1, add multiplicand to product.
  - Shift multiplicand left and multiplier right. Increment count.
  - Leave CALC when count = WIDTH-1.
- FIX: one cycle.
  - p = neg ? -product : product (two's complement, 64 bits).
  - If acc_en: p += {acc_hi,acc_lo} for long ops, or p[31:0] += acc_lo for MUL. Addition is modulo 2^64 (long) or 2^32 (MUL), with no overflow indication.
  - Register p into result_lo/result_hi. result_hi = 0 for MUL.
  - Register flag_n/flag_z: bit 31 and 32-bit zero for MUL; bit 63 and 64-bit zero for long ops.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge 0 → CALC cycles 1..32 → FIX cycle 33 → done high during cycle 34. Next start is accepted in cycle 35.
- Outputs hold their value from FIX until the next FIX or reset.
- start while busy=1 is ignored; the request is lost, and the core holds start until busy=0.
- Operand changes after start is accepted have no effect.
- Reset mid-operation: immediate return to IDLE with all outputs cleared; no done pulse.
- No clock enable; the unit runs every cycle.

Decomposition:
- Shared package arm_mul_pkg:
  - op encodings MUL_OP_MUL/UMULL/SMULL
  - state enum IDLE/CALC/FIX/DONE
  - localparam for the count width, $clog2(WIDTH)
- Optional sub-module arm_mul_fsm holds the state register, counter and busy/done decode. The shift-add datapath and FIX stage stay in arm_mul_unit.

Test Plan:
- MUL a=7, b=6, acc_en=0 → done in cycle 34; result_lo=0x0000002A, result_hi=0, flag_n=0, flag_z=0; busy high cycles 1..34.
- UMULL a=b=0xFFFFFFFF → result_hi=0xFFFFFFFE, result_lo=0x00000001, flag_n=1, flag_z=0.
- SMULL a=0xFFFFFFFE (−2), b=3 → result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFA, flag_n=1. Then SMULL a=b=0x80000000 → result_hi=0x40000000, result_lo=0, flag_n=0.
- UMULL with accumulate: a=2, b=3, acc_en=1, acc_hi=0, acc_lo=0xFFFFFFFF → result_hi=0x00000001, result_lo=0x00000005. Then MLA a=0x10000, b=0x10000, acc_lo=1 → result_lo=0x00000001, result_hi=0.
- MUL a=0, b=0x1234 → flag_z=1. Second start pulsed in cycle 10 with a=5, b=5 → ignored: one done pulse only, result_lo=0.
- Reset=0 asserted in cycle 15 of a UMULL → busy/done/results 0 immediately; no done. After release, a new MUL 3×3 gives result_lo=9 at cycle 34.
